regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Writeback-side master for the 32x32 register file: accepts destination/data results from the execute/memory path over a valid/ready handshake.
- Buffers results in a small in-order queue and drives the register file write port (wr_en, wp_num, wp_data), one write per cycle.
- Gives the decode side a pending flag and youngest-value bypass for each of the two read-port register numbers, so reads never see stale data while writes are in flight.

Parameters:
- DATA_W, 32, data width of results and of the write port.
- ADDR_W, 5, register number width (32 registers).
- DEPTH, 4, result queue entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- res_valid  in  1  result offered this cycle.
- res_ready  out  1  queue can accept; equals (count < DEPTH), combinational from count.
- res_dest  in  ADDR_W  destination register number.
- res_data  in  DATA_W  result value.
- wb_hold  in  1  when 1, no queue pop this cycle.
- flush  in  1  discard all queued, not-yet-written results.
- wr_en  out  1  register file write enable; registered.
- wp_num  out  ADDR_W  register file write number; registered.
- wp_data  out  DATA_W  register file write data; registered.
- rpa_num  in  ADDR_W  read port A register number, from decode.
- rpb_num  in  ADDR_W  read port B register number, from decode.
- rpa_pending  out  1  a write to rpa_num is queued or on the write port.
- rpb_pending  out  1  same, for rpb_num.
- rpa_byp  out  DATA_W  youngest in-flight value for rpa_num; 0 when not pending.
- rpb_byp  out  DATA_W  same, for rpb_num.

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, read/write pointers=0, wr_en=0, wp_num=0, wp_data=0, all entry valid bits cleared. Outputs: res_ready=1, pending=0, byp=0.
- Push: happens when res_valid & res_ready & ~flush.
  - res_dest==0: handshake completes but nothing is queued ($zero is never written).
  - Otherwise: {dest, data} is written at the write pointer; the pointer wraps modulo DEPTH; count is incremented.
- Pop: happens when count>0 & ~wb_hold & ~flush.
  - Next cycle: wr_en=1, wp_num/wp_data = head entry; the read pointer wraps modulo DEPTH.
  - With no pop, wr_en=0 next cycle and wp_num/wp_data hold their values.
- Latency: result pushed at edge N into an empty queue, no hold -> popped at edge N+1 -> wr_en=1 during cycle N+1 to N+2. The register file captures it at edge N+2.
- Throughput: one push and one pop per cycle; a simultaneous push and pop leaves count unchanged.
- Full: count==DEPTH forces res_ready=0, even if a pop occurs that cycle (no pass-through).
- Empty: no pop, wr_en=0.
- Occupancy states, from count: EMPTY (0), ACTIVE (1..DEPTH-1), FULL (DEPTH).
  - EMPTY -> ACTIVE on push.
  - ACTIVE -> FULL on push without pop.
  - FULL -> ACTIVE on pop.
  - ACTIVE -> EMPTY on pop of the last entry without push.
  - Any state -> EMPTY on flush.
- flush:
  - At the next edge: count=0, pointers=0, wr_en=0.
  - A push or pop in the same cycle is ignored.
  - A write already on the port (wr_en=1 in the flush cycle) still completes.
- Pending and bypass (combinational):
  - Candidates: every queued entry, plus the write-port stage when wr_en=1.
  - A candidate matches when its dest equals the port number and the number is nonzero.
  - Youngest match wins, in order: newest queue entry first, write-port stage last.
  - Register 0 is never pending and its bypass is 0.
- Duplicate destinations are legal; later results overwrite earlier ones in program order.

Decomposition:
- Package regfile_pkg: DATA_W/ADDR_W constants, typedef wb_entry_t {dest, data}, constant REG_ZERO = 0.
- Sub-module wb_fifo: the DEPTH-entry circular buffer with pointers and count. It exposes the entry array for the bypass compare.
- The bypass/pending priority compare stays in the top level.

Test Plan:
- Reset then idle: rst_n low mid-operation with 3 entries queued -> immediately wr_en=0, res_ready=1, rpa_pending=0.
- Single write: push dest=1 data=6 at edge N -> wr_en=1, wp_num=1, wp_data=6 in cycle N+1 only. rpa_num=1 gives pending=1 and byp=6 from cycle N until edge N+2.
- $zero drop: push dest=0 data=3 -> res_ready handshake occurs, wr_en never asserts, rpa_num=0 gives pending=0.
- Full/backpressure: wb_hold=1, push dests 1..4 (data 3,6,9,12) -> res_ready=0 after 4th. A 5th push (dest=5, data=15) is held by the source until wb_hold drops. Writes then issue in order 1,2,3,4,5 on consecutive cycles.
- Bypass priority: queue dest=2 data=9, then dest=2 data=20 with wb_hold=1 -> rpb_num=2 gives byp=20. After the first pop, still 20. After both writes complete, pending=0.
- Flush: 3 entries queued plus one on the port, assert flush one cycle -> the port write completes, no further wr_en, count=0, res_ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, queue entry type and occupancy decode for the register file writeback path.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'd0,
    OCC_ACTIVE = 2'd1,
    OCC_FULL   = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input int unsigned count, input int unsigned depth);
    if (count == 0) return OCC_EMPTY;
    if (count >= depth) return OCC_FULL;
    return OCC_ACTIVE;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Result handshake, register file write port and decode read-port bypass signals.
interface regfile_wb_ctrl_if;
  import regfile_pkg::*;

  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_dest;
  logic [DATA_W-1:0] res_data;
  logic              wb_hold;
  logic              flush;
  logic              wr_en;
  logic [ADDR_W-1:0] wp_num;
  logic [DATA_W-1:0] wp_data;
  logic [ADDR_W-1:0] rpa_num;
  logic [ADDR_W-1:0] rpb_num;
  logic              rpa_pending;
  logic              rpb_pending;
  logic [DATA_W-1:0] rpa_byp;
  logic [DATA_W-1:0] rpb_byp;

  modport master (
    input  res_valid, res_dest, res_data, wb_hold, flush, rpa_num, rpb_num,
    output res_ready, wr_en, wp_num, wp_data,
    output rpa_pending, rpb_pending, rpa_byp, rpb_byp
  );

  modport slave (
    output res_valid, res_dest, res_data, wb_hold, flush, rpa_num, rpb_num,
    input  res_ready, wr_en, wp_num, wp_data,
    input  rpa_pending, rpb_pending, rpa_byp, rpb_byp
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order circular result buffer; entries visible one cycle after push, one push and one pop per cycle.
// Caller qualifies push (not full) and pop (not empty); flush clears pointers, count and valid bits.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             push_dat,
  input  logic                  pop,
  input  logic                  flush,
  output wb_entry_t             head_dat,
  output logic [CNT_W-1:0]      count,
  output logic [PTR_W-1:0]      rd_ptr,
  output wb_entry_t [DEPTH-1:0] ents,
  output logic [DEPTH-1:0]      ent_vld
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = cnt_q;
  assign rd_ptr   = rd_ptr_q;
  assign ents     = mem_q;
  assign ent_vld  = vld_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback master: queues results and drives one registered regfile write per cycle (push to wr_en in 1 cycle).
// res_ready drops only when the queue is full; decode gets pending/youngest-value bypass per read port.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  regfile_wb_ctrl_if.master bus
);

  localparam int          PTR_W   = $clog2(DEPTH);
  localparam int          CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned DEPTH_U = DEPTH;

  logic                  push, pop;
  wb_entry_t             push_dat, head_dat;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      rd_ptr;
  wb_entry_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]      ent_vld;
  occ_e                  occ;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wp_num_q, wp_num_d;
  logic [DATA_W-1:0] wp_data_q, wp_data_d;

  logic [1:0][ADDR_W-1:0] rp_num;
  logic [1:0]             rp_hit;
  logic [1:0][DATA_W-1:0] rp_byp;
  logic [PTR_W-1:0]       idx;

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign occ           = occ_of(32'(count), DEPTH_U);
  assign bus.res_ready = (occ != OCC_FULL);

  // $zero results complete the handshake but are never queued.
  assign push          = bus.res_valid & bus.res_ready & ~bus.flush & (bus.res_dest != REG_ZERO);
  assign pop           = (occ != OCC_EMPTY) & ~bus.wb_hold & ~bus.flush;
  assign push_dat.dest = bus.res_dest;
  assign push_dat.data = bus.res_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (bus.flush),
    .head_dat (head_dat),
    .count    (count),
    .rd_ptr   (rd_ptr),
    .ents     (ents),
    .ent_vld  (ent_vld)
  );

  always_comb begin
    wr_en_d   = pop;
    wp_num_d  = wp_num_q;
    wp_data_d = wp_data_q;
    if (pop) begin
      wp_num_d  = head_dat.dest;
      wp_data_d = head_dat.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wp_num_q  <= '0;
      wp_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wp_num_q  <= wp_num_d;
      wp_data_q <= wp_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wp_num  = wp_num_q;
  assign bus.wp_data = wp_data_q;

  assign rp_num = {bus.rpb_num, bus.rpa_num};

  // Scan oldest to youngest so later matches overwrite: write-port stage, then queue from head.
  always_comb begin
    rp_hit = '0;
    rp_byp = '0;
    idx    = '0;
    for (int p = 0; p < 2; p++) begin
      if (wr_en_q && (wp_num_q == rp_num[p])) begin
        rp_hit[p] = 1'b1;
        rp_byp[p] = wp_data_q;
      end
      for (int a = 0; a < DEPTH; a++) begin
        idx = rd_ptr + PTR_W'(a);
        if (ent_vld[idx] && (ents[idx].dest == rp_num[p])) begin
          rp_hit[p] = 1'b1;
          rp_byp[p] = ents[idx].data;
        end
      end
      if (rp_num[p] == REG_ZERO) begin
        rp_hit[p] = 1'b0;
        rp_byp[p] = '0;
      end
    end
  end

  assign bus.rpa_pending = rp_hit[0];
  assign bus.rpb_pending = rp_hit[1];
  assign bus.rpa_byp     = rp_byp[0];
  assign bus.rpb_byp     = rp_byp[1];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_regfile_wb_ctrl;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [4:0]  d;
    logic [31:0] v;
  } ent_t;

  ent_t        mq[$];
  logic        m_wr_en;
  logic [4:0]  m_num;
  logic [31:0] m_data;
  logic [4:0]  obs[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Youngest pending value for a register: newest queued result first, then the write port.
  function automatic logic [32:0] model_byp(input logic [4:0] n);
    if (n == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].d == n) return {1'b1, mq[i].v};
    if (m_wr_en && (m_num == n)) return {1'b1, m_data};
    return 33'd0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wr_en = 1'b0;
    m_num   = '0;
    m_data  = '0;
  endtask

  task automatic drive_idle();
    bus.res_valid = 1'b0;
    bus.res_dest  = '0;
    bus.res_data  = '0;
    bus.wb_hold   = 1'b0;
    bus.flush     = 1'b0;
    bus.rpa_num   = '0;
    bus.rpb_num   = '0;
  endtask

  // One clock cycle: drive, check all outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [4:0] d, input logic [31:0] dat,
                      input logic h, input logic f, input logic [4:0] a, input logic [4:0] b,
                      output logic acc);
    logic [32:0] ea, eb;
    logic        m_ready;
    ent_t        e;
    @(negedge clk);
    bus.res_valid = v;
    bus.res_dest  = d;
    bus.res_data  = dat;
    bus.wb_hold   = h;
    bus.flush     = f;
    bus.rpa_num   = a;
    bus.rpb_num   = b;
    #1;
    m_ready = (mq.size() < DEPTH);
    ea = model_byp(a);
    eb = model_byp(b);
    check_eq("res_ready",   64'(bus.res_ready),   64'(m_ready));
    check_eq("wr_en",       64'(bus.wr_en),       64'(m_wr_en));
    check_eq("wp_num",      64'(bus.wp_num),      64'(m_num));
    check_eq("wp_data",     64'(bus.wp_data),     64'(m_data));
    check_eq("rpa_pending", 64'(bus.rpa_pending), 64'(ea[32]));
    check_eq("rpa_byp",     64'(bus.rpa_byp),     64'(ea[31:0]));
    check_eq("rpb_pending", 64'(bus.rpb_pending), 64'(eb[32]));
    check_eq("rpb_byp",     64'(bus.rpb_byp),     64'(eb[31:0]));
    if (bus.wr_en) obs.push_back(bus.wp_num);
    acc = v && m_ready && !f;
    if (f) begin
      mq.delete();
      m_wr_en = 1'b0;
    end else begin
      if ((mq.size() > 0) && !h) begin
        m_wr_en = 1'b1;
        m_num   = mq[0].d;
        m_data  = mq[0].v;
        void'(mq.pop_front());
      end else begin
        m_wr_en = 1'b0;
      end
      if (acc && (d != 5'd0)) begin
        e.d = d;
        e.v = dat;
        mq.push_back(e);
      end
    end
  endtask

  task automatic do_reset(input logic [4:0] probe);
    @(negedge clk);
    drive_idle();
    bus.rpa_num = probe;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wr_en",       64'(bus.wr_en),       64'd0);
    check_eq("rst_res_ready",   64'(bus.res_ready),   64'd1);
    check_eq("rst_rpa_pending", 64'(bus.rpa_pending), 64'd0);
    check_eq("rst_rpa_byp",     64'(bus.rpa_byp),     64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        acc;
    int          k;
    logic        sv;
    logic [4:0]  sd;
    logic [31:0] sdat;

    drive_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, 2, acc);

    // Single write: visible as pending immediately, on the port one cycle later.
    obs.delete();
    step(1, 5'd1, 32'd6, 0, 0, 5'd1, 5'd0, acc);
    check_eq("single_acc", 64'(acc), 64'd1);
    repeat (4) step(0, 0, 0, 0, 0, 5'd1, 5'd1, acc);
    check_eq("single_nwrites", 64'(obs.size()), 64'd1);
    if (obs.size() > 0) check_eq("single_num", 64'(obs[0]), 64'd1);

    // $zero result: accepted, never written, never pending.
    obs.delete();
    step(1, 5'd0, 32'd3, 0, 0, 5'd0, 5'd0, acc);
    check_eq("zero_acc", 64'(acc), 64'd1);
    repeat (3) step(0, 0, 0, 0, 0, 5'd0, 5'd0, acc);
    check_eq("zero_nwrites", 64'(obs.size()), 64'd0);

    // Fill under hold, fifth result waits until hold drops, writes drain in order.
    obs.delete();
    for (int i = 1; i <= 4; i++) begin
      step(1, 5'(i), 32'(3 * i), 1, 0, 5'(i), 5'd5, acc);
      check_eq("full_fill_acc", 64'(acc), 64'd1);
    end
    repeat (2) begin
      step(1, 5'd5, 32'd15, 1, 0, 5'd4, 5'd5, acc);
      check_eq("full_blocked", 64'(acc), 64'd0);
    end
    k = 0;
    acc = 1'b0;
    while (!acc && (k < 10)) begin
      step(1, 5'd5, 32'd15, 0, 0, 5'd5, 5'd1, acc);
      k++;
    end
    check_eq("full_accept", 64'(acc), 64'd1);
    repeat (8) step(0, 0, 0, 0, 0, 5'd3, 5'd5, acc);
    check_eq("full_nwrites", 64'(obs.size()), 64'd5);
    for (int i = 0; (i < obs.size()) && (i < 5); i++)
      check_eq("full_order", 64'(obs[i]), 64'(i + 1));

    // Duplicate destination: bypass always returns the younger value.
    step(1, 5'd2, 32'd9,  1, 0, 5'd0, 5'd2, acc);
    step(1, 5'd2, 32'd20, 1, 0, 5'd0, 5'd2, acc);
    step(0, 0, 0, 1, 0, 5'd0, 5'd2, acc);
    check_eq("prio_byp", 64'(bus.rpb_byp), 64'd20);
    repeat (4) step(0, 0, 0, 0, 0, 5'd2, 5'd2, acc);

    // Flush with one write on the port: that write completes, nothing after.
    for (int i = 0; i < 4; i++) step(1, 5'(3 + i), 32'(100 + i), 1, 0, 5'd3, 5'd6, acc);
    step(0, 0, 0, 0, 0, 5'd4, 5'd6, acc);
    obs.delete();
    step(1, 5'd7, 32'd77, 0, 1, 5'd4, 5'd6, acc);
    check_eq("flush_no_accept", 64'(acc), 64'd0);
    repeat (4) step(0, 0, 0, 0, 0, 5'd4, 5'd7, acc);
    check_eq("flush_nwrites", 64'(obs.size()), 64'd1);

    // Asynchronous reset with a write on the port and three entries queued.
    for (int i = 0; i < 4; i++) step(1, 5'(8 + i), 32'(200 + i), 1, 0, 5'd9, 5'd10, acc);
    step(0, 0, 0, 0, 0, 5'd9, 5'd10, acc);
    do_reset(5'd10);
    step(0, 0, 0, 0, 0, 5'd10, 5'd11, acc);

    // Random traffic; the source holds an offer until it is accepted.
    sv = 1'b0;
    sd = '0;
    sdat = '0;
    repeat (600) begin
      if (!sv) begin
        sv   = ($urandom_range(0, 3) != 0);
        sd   = 5'($urandom_range(0, 7));
        sdat = $urandom;
      end
      step(sv, sd, sdat, ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
      if (acc) sv = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
